jacobi_pair_sequencer: RTL and testbench

- Parametrised successor of the fixed 8x8 angle-fetch stage of the Jacobi main controller.
- For an N x N symmetric matrix held in dual-port RAM, it generates the full round-robin (tournament) pair ordering over N-1 rounds.
- For each pair (i,j) it fetches a_ii, a_jj and a_ij, then presents x = a_jj - a_ii and y = 2*a_ij to the vectoring CORDIC under a valid/ready handshake.
- One start runs one complete sweep of N*(N-1)/2 pairs.

---
 rtl/jacobi_pair_sequencer_pkg.sv | 32 +++
 rtl/jacobi_pair_sequencer_rr_order.sv | 63 ++++++
 rtl/jacobi_pair_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_jacobi_pair_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jacobi_pair_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// jacobi_pair_sequencer_pkg
// Shared definitions for the Jacobi pair sequencer:
//   - jacobi_pair_seq_fsm_t : sequencer FSM state encoding
//   - JACOBI_N / JACOBI_DATA_W / JACOBI_ADDR_WIDTH : default build sizes
//   - jacobi_addr()         : row-major RAM address of element (r,c)
// ---------------------------------------------------------------------------
package jacobi_pair_sequencer_pkg;

  localparam int JACOBI_N          = 8;
  localparam int JACOBI_DATA_W     = 16;
  localparam int JACOBI_ADDR_WIDTH = 7;
  localparam int JACOBI_LG_N       = $clog2(JACOBI_N);

  typedef enum logic [2:0] {
    IDLE,
    RD_DIAG,
    RD_OFF,
    CALC,
    PRESENT,
    ROTATE
  } jacobi_pair_seq_fsm_t;

  // Row stride is a power of two, so the row index is simply shifted.
  function automatic int unsigned jacobi_addr(input int unsigned r,
                                              input int unsigned c,
                                              input int unsigned base,
                                              input int unsigned lg_n = JACOBI_LG_N);
    return base + (r << lg_n) + c;
  endfunction

endpackage

// File: rtl/jacobi_pair_sequencer_rr_order.sv
// ---------------------------------------------------------------------------
// jacobi_rr_order
// Round-robin (tournament) ordering register p[0..N-1] for the Jacobi sweep.
//   clk, rst   : clock, synchronous active-high reset (p := identity)
//   init_i     : load identity ordering
//   rotate_i   : p[0] fixed, p[1] <= p[N-1], p[m] <= p[m-1] for m >= 2
//   sel_k_i    : pair slot k, 0..N/2-1
//   pair_i_o   : min(p[k], p[N-1-k])
//   pair_j_o   : max(p[k], p[N-1-k])
// The pair outputs are taken from the ordering as it will be after this
// clock edge, so the controller can issue addresses for the first pair of
// a new round in the same cycle the rotation is applied.
// ---------------------------------------------------------------------------
module jacobi_rr_order
  import jacobi_pair_sequencer_pkg::*;
#(
  parameter  int N     = JACOBI_N,
  localparam int IDX_W = $clog2(N),
  localparam int K_W   = IDX_W - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_i,
  input  logic             rotate_i,
  input  logic [K_W-1:0]   sel_k_i,
  output logic [IDX_W-1:0] pair_i_o,
  output logic [IDX_W-1:0] pair_j_o
);

  logic [IDX_W-1:0] p_q [N];
  logic [IDX_W-1:0] p_d [N];
  logic [IDX_W-1:0] lo_idx;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] elem_a;
  logic [IDX_W-1:0] elem_b;

  always_comb begin
    for (int m = 0; m < N; m++) p_d[m] = p_q[m];
    if (init_i) begin
      for (int m = 0; m < N; m++) p_d[m] = IDX_W'(m);
    end else if (rotate_i) begin
      p_d[0] = p_q[0];
      p_d[1] = p_q[N-1];
      for (int m = 2; m < N; m++) p_d[m] = p_q[m-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int m = 0; m < N; m++) p_q[m] <= IDX_W'(m);
    end else begin
      for (int m = 0; m < N; m++) p_q[m] <= p_d[m];
    end
  end

  assign lo_idx   = {1'b0, sel_k_i};
  assign hi_idx   = IDX_W'(N - 1) - lo_idx;
  assign elem_a   = p_d[lo_idx];
  assign elem_b   = p_d[hi_idx];
  assign pair_i_o = (elem_a < elem_b) ? elem_a : elem_b;
  assign pair_j_o = (elem_a < elem_b) ? elem_b : elem_a;

endmodule

// File: rtl/jacobi_pair_sequencer.sv
// ---------------------------------------------------------------------------
// jacobi_pair_sequencer
// Walks one full round-robin Jacobi sweep (N*(N-1)/2 pairs over N-1 rounds)
// of an N x N symmetric matrix in dual-port RAM.  For each pair (i,j) it
// reads a_ii, a_jj, a_ij and presents x = a_jj - a_ii, y = 2*a_ij, z = 0 to
// the vectoring CORDIC over a valid/ready handshake.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start_i               : start a sweep (ignored while busy / on done cycle)
//   busy_o, sweep_done_o  : sweep in progress / one-cycle end-of-sweep pulse
//   round_o               : current round 0..N-2
//   ram_en_*_o, ram_addr_*_o, ram_dout_*_i : read-only dual-port RAM, 1-cycle latency
//   out_x_o, out_y_o, out_z_o : CORDIC operands, DATA_W+1 bits signed
//   out_i_o, out_j_o      : pair indices, i < j
//   out_vld_o, out_rdy_i  : output handshake
//
// Build option: define JACOBI_PAIR_SEQ_SKIP_ZERO_EN to drop pairs whose
// off-diagonal element is already zero (no output is presented for them).
// ---------------------------------------------------------------------------
module jacobi_pair_sequencer
  import jacobi_pair_sequencer_pkg::*;
#(
  parameter  int N         = JACOBI_N,
  parameter  int DATA_W    = JACOBI_DATA_W,
  parameter  int ADDR_W    = JACOBI_ADDR_WIDTH,
  parameter  int BASE_ADDR = 0,
  localparam int IDX_W     = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     sweep_done_o,
  output logic [IDX_W-1:0]         round_o,
  output logic                     ram_en_a_o,
  output logic                     ram_en_b_o,
  output logic [ADDR_W-1:0]        ram_addr_a_o,
  output logic [ADDR_W-1:0]        ram_addr_b_o,
  input  logic signed [DATA_W-1:0] ram_dout_a_i,
  input  logic signed [DATA_W-1:0] ram_dout_b_i,
  output logic signed [DATA_W:0]   out_x_o,
  output logic signed [DATA_W:0]   out_y_o,
  output logic signed [DATA_W:0]   out_z_o,
  output logic [IDX_W-1:0]         out_i_o,
  output logic [IDX_W-1:0]         out_j_o,
  output logic                     out_vld_o,
  input  logic                     out_rdy_i
);

  localparam int               K_W        = IDX_W - 1;
  localparam logic [K_W-1:0]   LAST_K     = K_W'(N / 2 - 1);
  localparam logic [IDX_W-1:0] LAST_ROUND = IDX_W'(N - 2);

  // Full-precision difference: both operands widened by one sign bit first.
  function automatic logic signed [DATA_W:0] ext_diff(input logic signed [DATA_W-1:0] minu,
                                                      input logic signed [DATA_W-1:0] subt);
    logic signed [DATA_W:0] m_ext;
    logic signed [DATA_W:0] s_ext;
    m_ext = {minu[DATA_W-1], minu};
    s_ext = {subt[DATA_W-1], subt};
    return m_ext - s_ext;
  endfunction

  // Doubling into one extra bit is exact.
  function automatic logic signed [DATA_W:0] dbl_ext(input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W:0] r;
    r = {v, 1'b0};
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] pair_addr(input logic [IDX_W-1:0] r,
                                                  input logic [IDX_W-1:0] c);
    return ADDR_W'(jacobi_addr(32'(r), 32'(c), 32'(BASE_ADDR), 32'(IDX_W)));
  endfunction

  jacobi_pair_seq_fsm_t state_q, state_d;
  logic [K_W-1:0]          k_q, k_d;
  logic [IDX_W-1:0]        round_q, round_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    en_a_q, en_a_d;
  logic                    en_b_q, en_b_d;
  logic [ADDR_W-1:0]       addr_a_q, addr_a_d;
  logic [ADDR_W-1:0]       addr_b_q, addr_b_d;
  logic signed [DATA_W:0]  out_x_q, out_x_d;
  logic signed [DATA_W:0]  out_y_q, out_y_d;
  logic [IDX_W-1:0]        out_i_q, out_i_d;
  logic [IDX_W-1:0]        out_j_q, out_j_d;
  logic                    vld_q, vld_d;
  logic signed [DATA_W-1:0] a_ii_q, a_ii_d;
  logic signed [DATA_W-1:0] a_jj_q, a_jj_d;

  logic             skip_zero;
  logic             adv;
  logic             last_k;
  logic             go_diag;
  logic             rr_init;
  logic             rr_rotate;
  logic [K_W-1:0]   rr_sel_k;
  logic [IDX_W-1:0] rr_i;
  logic [IDX_W-1:0] rr_j;

  jacobi_rr_order #(.N(N)) u_order (
    .clk      (clk),
    .rst      (rst),
    .init_i   (rr_init),
    .rotate_i (rr_rotate),
    .sel_k_i  (rr_sel_k),
    .pair_i_o (rr_i),
    .pair_j_o (rr_j)
  );

  // Ordering control depends only on state, so the pair lookup never loops
  // back through the next-state logic. adv = "this pair is finished".
  always_comb begin
    skip_zero = 1'b0;
`ifdef JACOBI_PAIR_SEQ_SKIP_ZERO_EN
    skip_zero = (ram_dout_a_i == '0);
`endif
    adv       = ((state_q == PRESENT) && out_rdy_i) || ((state_q == CALC) && skip_zero);
    last_k    = (k_q == LAST_K);
    rr_init   = (state_q == IDLE);
    rr_rotate = (state_q == ROTATE);
    if ((state_q == IDLE) || (state_q == ROTATE)) begin
      rr_sel_k = '0;
    end else if (adv && !last_k) begin
      rr_sel_k = k_q + 1'b1;
    end else begin
      rr_sel_k = k_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    round_d  = round_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    en_a_d   = 1'b0;
    en_b_d   = 1'b0;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    out_x_d  = out_x_q;
    out_y_d  = out_y_q;
    out_i_d  = out_i_q;
    out_j_d  = out_j_q;
    vld_d    = vld_q;
    a_ii_d   = a_ii_q;
    a_jj_d   = a_jj_q;
    go_diag  = 1'b0;

    case (state_q)
      IDLE: begin
        // A start landing on the done-pulse cycle belongs to the old sweep.
        if (start_i && !done_q) begin
          k_d     = '0;
          round_d = '0;
          busy_d  = 1'b1;
          go_diag = 1'b1;
        end
      end
      RD_DIAG: begin
        state_d  = RD_OFF;
        en_a_d   = 1'b1;
        addr_a_d = pair_addr(rr_i, rr_j);
      end
      RD_OFF: begin
        state_d = CALC;
        a_ii_d  = ram_dout_a_i;
        a_jj_d  = ram_dout_b_i;
      end
      CALC: begin
        if (!skip_zero) begin
          out_x_d = ext_diff(a_jj_q, a_ii_q);
          out_y_d = dbl_ext(ram_dout_a_i);
          out_i_d = rr_i;
          out_j_d = rr_j;
          vld_d   = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (out_rdy_i) vld_d = 1'b0;
      end
      ROTATE: begin
        k_d = '0;
        if (round_q == LAST_ROUND) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          round_d = round_q + 1'b1;
          go_diag = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (adv) begin
      if (last_k) begin
        state_d = ROTATE;
      end else begin
        k_d     = k_q + 1'b1;
        go_diag = 1'b1;
      end
    end

    if (go_diag) begin
      state_d  = RD_DIAG;
      en_a_d   = 1'b1;
      en_b_d   = 1'b1;
      addr_a_d = pair_addr(rr_i, rr_i);
      addr_b_d = pair_addr(rr_j, rr_j);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      round_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      en_a_q   <= 1'b0;
      en_b_q   <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      out_x_q  <= '0;
      out_y_q  <= '0;
      out_i_q  <= '0;
      out_j_q  <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      round_q  <= round_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      en_a_q   <= en_a_d;
      en_b_q   <= en_b_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      out_x_q  <= out_x_d;
      out_y_q  <= out_y_d;
      out_i_q  <= out_i_d;
      out_j_q  <= out_j_d;
      vld_q    <= vld_d;
    end
  end

  // Diagonal operand holding registers
  always_ff @(posedge clk) begin
    a_ii_q <= a_ii_d;
    a_jj_q <= a_jj_d;
  end

  assign busy_o       = busy_q;
  assign sweep_done_o = done_q;
  assign round_o      = round_q;
  assign ram_en_a_o   = en_a_q;
  assign ram_en_b_o   = en_b_q;
  assign ram_addr_a_o = addr_a_q;
  assign ram_addr_b_o = addr_b_q;
  assign out_x_o      = out_x_q;
  assign out_y_o      = out_y_q;
  assign out_z_o      = '0;
  assign out_i_o      = out_i_q;
  assign out_j_o      = out_j_q;
  assign out_vld_o    = vld_q;

endmodule

// File: tb/tb_jacobi_pair_sequencer.sv
// ---------------------------------------------------------------------------
// tb_jacobi_pair_sequencer
// Directed bench for jacobi_pair_sequencer (N=8, DATA_W=16, ADDR_W=7).
// A behavioural dual-port RAM holds a(r,c) = 16*r + c at address 8*r + c.
// The expected pair order is a hand-written table of the 28 tournament
// pairs; expected x/y come from the bench's own RAM contents.
// ---------------------------------------------------------------------------
module tb_jacobi_pair_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                start_i;
  logic                out_rdy_i;
  logic                busy_o;
  logic                sweep_done_o;
  logic [2:0]          round_o;
  logic                ram_en_a_o;
  logic                ram_en_b_o;
  logic [6:0]          ram_addr_a_o;
  logic [6:0]          ram_addr_b_o;
  logic signed [15:0]  ram_dout_a_i = '0;
  logic signed [15:0]  ram_dout_b_i = '0;
  logic signed [16:0]  out_x_o;
  logic signed [16:0]  out_y_o;
  logic signed [16:0]  out_z_o;
  logic [2:0]          out_i_o;
  logic [2:0]          out_j_o;
  logic                out_vld_o;

  logic signed [15:0]  mem [128];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int r;
    int i;
    int j;
  } vec_t;
  vec_t tbl [28];

  jacobi_pair_sequencer #(
    .N(8), .DATA_W(16), .ADDR_W(7), .BASE_ADDR(0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .busy_o       (busy_o),
    .sweep_done_o (sweep_done_o),
    .round_o      (round_o),
    .ram_en_a_o   (ram_en_a_o),
    .ram_en_b_o   (ram_en_b_o),
    .ram_addr_a_o (ram_addr_a_o),
    .ram_addr_b_o (ram_addr_b_o),
    .ram_dout_a_i (ram_dout_a_i),
    .ram_dout_b_i (ram_dout_b_i),
    .out_x_o      (out_x_o),
    .out_y_o      (out_y_o),
    .out_z_o      (out_z_o),
    .out_i_o      (out_i_o),
    .out_j_o      (out_j_o),
    .out_vld_o    (out_vld_o),
    .out_rdy_i    (out_rdy_i)
  );

  // Dual-port RAM, 1-cycle read latency
  always @(posedge clk) begin
    if (ram_en_a_o) ram_dout_a_i <= mem[ram_addr_a_o];
    if (ram_en_b_o) ram_dout_b_i <= mem[ram_addr_b_o];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_mem();
    for (int a = 0; a < 128; a++) mem[a] = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mem[r*8 + c] = 16'(16*r + c);
  endtask

  function automatic int ax(input int r, input int c);
    return int'(mem[r*8 + c]);
  endfunction

  // One full sweep from a start pulse. rand_rdy: 50% backpressure plus start
  // pulses while busy. skip_16: pair (1,6) expected to be absent.
  // chk_time: check cycle-exact latency with out_rdy_i held high.
  task automatic run_sweep(input bit rand_rdy, input bit skip_16, input bit chk_time);
    int idx, n_out, cyc, first_vld, done_cyc, n_done, post;
    bit held;
    int hx, hy, hi, hj;
    idx = 0; n_out = 0; first_vld = -1; done_cyc = -1; n_done = 0; post = 0;
    held = 1'b0; hx = 0; hy = 0; hi = 0; hj = 0;
    out_rdy_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 1;
    chk("busy_after_start", int'(busy_o), 1);
    for (int t = 0; t < 3000 && post < 6; t++) begin
      @(negedge clk);
      if (out_vld_o && first_vld < 0) first_vld = cyc;
      if (held) begin
        chk("hold_vld", int'(out_vld_o), 1);
        chk("hold_x", int'(out_x_o), hx);
        chk("hold_y", int'(out_y_o), hy);
        chk("hold_ij", int'(out_i_o) * 8 + int'(out_j_o), hi * 8 + hj);
        held = 1'b0;
      end
      if (out_vld_o) begin
        if (out_rdy_i) begin
          if (skip_16 && idx < 28 && tbl[idx].i == 1 && tbl[idx].j == 6) idx++;
          if (idx < 28) begin
            chk("pair_i", int'(out_i_o), tbl[idx].i);
            chk("pair_j", int'(out_j_o), tbl[idx].j);
            chk("round", int'(round_o), tbl[idx].r);
            chk("x", int'(out_x_o), ax(tbl[idx].j, tbl[idx].j) - ax(tbl[idx].i, tbl[idx].i));
            chk("y", int'(out_y_o), 2 * ax(tbl[idx].i, tbl[idx].j));
            chk("z", int'(out_z_o), 0);
          end
          idx++;
          n_out++;
        end else begin
          held = 1'b1;
          hx = int'(out_x_o); hy = int'(out_y_o);
          hi = int'(out_i_o); hj = int'(out_j_o);
        end
      end
      if (sweep_done_o) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0) post++;
      @(posedge clk); #1;
      cyc++;
      if (rand_rdy) out_rdy_i = 1'($urandom_range(0, 1));
      start_i = 1'b0;
      if (rand_rdy && (cyc == 30 || cyc == 75)) start_i = 1'b1;
      if (sweep_done_o) start_i = 1'b1;
    end
    start_i = 1'b0;
    chk("sweep_done_seen", int'(done_cyc >= 0), 1);
    chk("done_pulses", n_done, 1);
    chk("outputs", n_out, skip_16 ? 27 : 28);
    chk("idle_busy", int'(busy_o), 0);
    chk("idle_vld", int'(out_vld_o), 0);
    if (chk_time) begin
      chk("first_vld_cycle", first_vld, 4);
      chk("done_cycle", done_cyc, 120);
    end
  endtask

  initial begin
    int w, bad;
    bit skip_en;
    tbl = '{'{0,0,7}, '{0,1,6}, '{0,2,5}, '{0,3,4},
            '{1,0,6}, '{1,5,7}, '{1,1,4}, '{1,2,3},
            '{2,0,5}, '{2,4,6}, '{2,3,7}, '{2,1,2},
            '{3,0,4}, '{3,3,5}, '{3,2,6}, '{3,1,7},
            '{4,0,3}, '{4,2,4}, '{4,1,5}, '{4,6,7},
            '{5,0,2}, '{5,1,3}, '{5,4,7}, '{5,5,6},
            '{6,0,1}, '{6,2,7}, '{6,3,6}, '{6,4,5}};
`ifdef JACOBI_PAIR_SEQ_SKIP_ZERO_EN
    skip_en = 1'b1;
`else
    skip_en = 1'b0;
`endif
    rst = 1'b1; start_i = 1'b0; out_rdy_i = 1'b0;
    fill_mem();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(sweep_done_o), 0);
    chk("rst_vld", int'(out_vld_o), 0);
    chk("rst_en_a", int'(ram_en_a_o), 0);
    chk("rst_en_b", int'(ram_en_b_o), 0);
    chk("rst_round", int'(round_o), 0);
    chk("rst_x", int'(out_x_o), 0);
    chk("rst_y", int'(out_y_o), 0);
    chk("rst_ij", int'(out_i_o) + int'(out_j_o), 0);
    chk("rst_addr", int'(ram_addr_a_o) + int'(ram_addr_b_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full sweep, no backpressure, cycle-exact timing
    run_sweep(1'b0, 1'b0, 1'b1);

    // Same sweep under random backpressure and busy-time start pulses
    run_sweep(1'b1, 1'b0, 1'b0);

    // Extreme operands on the first pair (0,7)
    mem[0] = 16'sd32767;
    mem[63] = -16'sd32768;
    mem[7] = -16'sd32768;
    out_rdy_i = 1'b0;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    w = 0;
    @(negedge clk);
    while (!out_vld_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ext_vld", int'(out_vld_o), 1);
    chk("ext_x", int'(out_x_o), -65535);
    chk("ext_y", int'(out_y_o), -65536);
    chk("ext_ij", int'(out_i_o) * 8 + int'(out_j_o), 7);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    fill_mem();

    // Reset during round 1 aborts the sweep
    out_rdy_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    w = 0;
    @(negedge clk);
    while (round_o != 3'd1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("reached_round1", int'(round_o), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_round", int'(round_o), 0);
    chk("abort_en", int'(ram_en_a_o) + int'(ram_en_b_o), 0);
    bad = 0;
    repeat (150) begin
      @(negedge clk);
      if (sweep_done_o || ram_en_a_o || ram_en_b_o || out_vld_o || busy_o) bad++;
    end
    chk("quiet_after_abort", bad, 0);
    run_sweep(1'b0, 1'b0, 1'b1);

    // Zero off-diagonal element a(1,6)
    mem[1*8 + 6] = '0;
    run_sweep(1'b0, skip_en, !skip_en);
    fill_mem();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
